// File: rtl/iterative_divider_if.sv
// Request/response bundle between the pipeline and the iterative divider.
// The requester (pipeline side) uses the master modport; the divider uses
// the slave modport.
interface iterative_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             dbz;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, dbz
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, dbz
  );
endinterface

// File: rtl/iterative_divider.sv
// Multi-cycle restoring divider for the DIV/DIVU path.
// One trial subtraction per cycle over WIDTH cycles; the quotient goes to LO
// and the remainder to HI, announced by a one-cycle done pulse.
// Signed operation divides magnitudes and fixes the signs at the end:
// the quotient is negative when the operand signs differ, the remainder
// takes the sign of the dividend.
// Optional feature: define DIV_ZERO_DETECT_EN to short-circuit a zero
// divisor straight to DONE with dbz=1, quotient=all ones and
// remainder=dividend. Without it, dbz stays 0 and a zero divisor simply
// runs through the normal sequence.
module iterative_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic                clk,
  input logic                rst,
  iterative_divider_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;

  // acc starts as the dividend magnitude; each cycle its MSB is consumed and
  // a quotient bit is shifted in at the bottom, so after WIDTH cycles it
  // holds the unsigned quotient.
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] prem;
  logic [WIDTH-1:0] divisor_mag;
  logic             neg_q;
  logic             neg_r;

  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;

  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic             zero_div;

  logic [WIDTH:0]   trial;
  logic             trial_neg;
  logic [WIDTH-1:0] next_prem;
  logic [WIDTH-1:0] next_acc;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

`ifdef DIV_ZERO_DETECT_EN
  assign zero_div = (bus.divisor == '0);
`else
  assign zero_div = 1'b0;
`endif

  // Operand magnitudes and signs as seen at the start request.
  always_comb begin
    dvd_neg = bus.is_signed & bus.dividend[WIDTH-1];
    dvs_neg = bus.is_signed & bus.divisor[WIDTH-1];
    dvd_mag = dvd_neg ? (~bus.dividend + 1'b1) : bus.dividend;
    dvs_mag = dvs_neg ? (~bus.divisor + 1'b1) : bus.divisor;
  end

  // One restoring step: shift in the next dividend bit, try the subtraction,
  // keep it when non-negative. The partial remainder is always below 2^(WIDTH-1)
  // before the shift, so WIDTH+1 bits hold the trial and its sign bit.
  always_comb begin
    trial     = {prem, acc[WIDTH-1]} - {1'b0, divisor_mag};
    trial_neg = trial[WIDTH];
    next_prem = trial_neg ? {prem[WIDTH-2:0], acc[WIDTH-1]} : trial[WIDTH-1:0];
    next_acc  = {acc[WIDTH-2:0], ~trial_neg};
    q_fin     = neg_q ? (~next_acc + 1'b1) : next_acc;
    r_fin     = neg_r ? (~next_prem + 1'b1) : next_prem;
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      acc         <= '0;
      prem        <= '0;
      divisor_mag <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            busy_q <= 1'b1;
            if (zero_div) begin
              state  <= DONE;
              done_q <= 1'b1;
              dbz_q  <= 1'b1;
              quo_q  <= '1;
              rem_q  <= bus.dividend;
            end else begin
              state       <= RUN;
              acc         <= dvd_mag;
              divisor_mag <= dvs_mag;
              neg_q       <= dvd_neg ^ dvs_neg;
              neg_r       <= dvd_neg;
              prem        <= '0;
              count       <= CNT_W'(WIDTH - 1);
            end
          end
        end
        RUN: begin
          prem  <= next_prem;
          acc   <= next_acc;
          count <= count - CNT_W'(1);
          if (count == '0) begin
            state  <= DONE;
            done_q <= 1'b1;
            dbz_q  <= 1'b0;
            quo_q  <= q_fin;
            rem_q  <= r_fin;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.dbz       = dbz_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: table vectors, hand-written
// multi-cycle sequences and randomized operands against a plain-arithmetic
// reference model. Follows DIV_ZERO_DETECT_EN for the zero-divisor case.
module tb_iterative_divider;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic clk = 1'b0;
  logic rst;

  iterative_divider_if #(.WIDTH(W)) bus ();

  iterative_divider #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference: divide with 64-bit host arithmetic, which truncates toward
  // zero with the remainder taking the dividend's sign; b must be nonzero.
  function automatic void refModel(input logic sgn, input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa, sb, lq, lr;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    lq = sa / sb;
    lr = sa % sb;
    q  = lq[W-1:0];
    r  = lr[W-1:0];
  endfunction

  // Pulse start for one cycle; returns at the negedge of cycle T+1.
  task automatic applyStimulus(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.is_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
  endtask

  // Wait (bounded) for done; cycles counts from T+1 = 1.
  task automatic waitDone(input int startCycles, output int cycles, output bit busyAll);
    cycles  = startCycles;
    busyAll = 1'b1;
    while (bus.done !== 1'b1 && cycles < 100) begin
      if (bus.busy !== 1'b1) busyAll = 1'b0;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic runVector(input string name, input logic sgn, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] eq,
                           input logic [W-1:0] er, input logic edbz, input int elat);
    int cyc;
    bit busyAll;
    applyStimulus(sgn, a, b);
    waitDone(1, cyc, busyAll);
    checkOutput({name, " latency"}, W'(cyc), W'(elat));
    checkOutput({name, " quotient"}, bus.quotient, eq);
    checkOutput({name, " remainder"}, bus.remainder, er);
    checkOutput({name, " dbz"}, W'(bus.dbz), W'(edbz));
    checkOutput({name, " busy at done"}, W'(bus.busy), W'(1));
    if (elat > 1) checkOutput({name, " busy during run"}, W'(busyAll), W'(1));
    @(negedge clk);
    checkOutput({name, " done is a pulse"}, W'(bus.done), W'(0));
    checkOutput({name, " idle after done"}, W'(bus.busy), W'(0));
  endtask

  initial begin
    int cyc;
    bit busyAll;
    bit sawDone;
    logic sgn;
    logic [W-1:0] a, b, eq, er;

    vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd14,        32'd2};
    vecs[1] = '{1'b1, 32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2,  32'hFFFFFFFE};
    vecs[2] = '{1'b1, 32'd100,        32'hFFFFFFF9, 32'hFFFFFFF2,  32'd2};
    vecs[3] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,        32'hFFFFFFFE};
    vecs[4] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000,  32'd0};
    vecs[5] = '{1'b0, 32'h80000000,   32'hFFFFFFFF, 32'd0,         32'h80000000};
    vecs[6] = '{1'b0, 32'd0,          32'd5,        32'd0,         32'd0};
    vecs[7] = '{1'b0, 32'd7,          32'd100,      32'd0,         32'd7};
    vecs[8] = '{1'b0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF,  32'd0};
    vecs[9] = '{1'b1, 32'h7FFFFFFF,   32'h80000000, 32'd0,         32'h7FFFFFFF};

    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    rst           = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("reset busy", W'(bus.busy), W'(0));
    checkOutput("reset done", W'(bus.done), W'(0));
    checkOutput("reset dbz", W'(bus.dbz), W'(0));
    checkOutput("reset quotient", bus.quotient, '0);
    checkOutput("reset remainder", bus.remainder, '0);

    $display("[TB] table vectors");
    for (int i = 0; i < 10; i++) begin
      runVector($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
                vecs[i].q, vecs[i].r, 1'b0, LAT);
    end

    $display("[TB] divide by zero");
`ifdef DIV_ZERO_DETECT_EN
    runVector("dbz unsigned", 1'b0, 32'h1234, 32'd0, 32'hFFFFFFFF, 32'h1234, 1'b1, 1);
    runVector("dbz signed", 1'b1, 32'hFFFFF000, 32'd0, 32'hFFFFFFFF, 32'hFFFFF000, 1'b1, 1);
`else
    runVector("dbz unsigned", 1'b0, 32'h1234, 32'd0, 32'hFFFFFFFF, 32'h1234, 1'b0, LAT);
`endif
    runVector("after dbz", 1'b0, 32'd50, 32'd6, 32'd8, 32'd2, 1'b0, LAT);

    $display("[TB] start during run is ignored");
    applyStimulus(1'b0, 32'd1000, 32'd3);
    repeat (4) @(negedge clk);
    bus.is_signed = 1'b1;
    bus.dividend  = 32'hFFFF0000;
    bus.divisor   = 32'd5;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone(6, cyc, busyAll);
    checkOutput("ignore latency", W'(cyc), W'(LAT));
    checkOutput("ignore quotient", bus.quotient, 32'd333);
    checkOutput("ignore remainder", bus.remainder, 32'd1);
    @(negedge clk);

    $display("[TB] reset aborts a run");
    applyStimulus(1'b0, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort busy", W'(bus.busy), W'(0));
    checkOutput("abort done", W'(bus.done), W'(0));
    checkOutput("abort quotient", bus.quotient, '0);
    checkOutput("abort remainder", bus.remainder, '0);
    sawDone = 1'b0;
    repeat (LAT + 5) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) sawDone = 1'b1;
    end
    checkOutput("abort no done", W'(sawDone), W'(0));
    runVector("after abort", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, LAT);

    $display("[TB] back-to-back");
    applyStimulus(1'b0, 32'd12345, 32'd10);
    waitDone(1, cyc, busyAll);
    checkOutput("b2b first quotient", bus.quotient, 32'd1234);
    bus.is_signed = 1'b0;
    bus.dividend  = 32'd999;
    bus.divisor   = 32'd9;
    bus.start     = 1'b1;
    @(negedge clk);
    checkOutput("start in done ignored", W'(bus.busy), W'(0));
    refModel(1'b1, 32'h7FFFFFFF, 32'hFFFFFFFE, eq, er);
    bus.is_signed = 1'b1;
    bus.dividend  = 32'h7FFFFFFF;
    bus.divisor   = 32'hFFFFFFFE;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("b2b accepted", W'(bus.busy), W'(1));
    checkOutput("b2b hold quotient", bus.quotient, 32'd1234);
    checkOutput("b2b hold remainder", bus.remainder, 32'd5);
    waitDone(1, cyc, busyAll);
    checkOutput("b2b latency", W'(cyc), W'(LAT));
    checkOutput("b2b second quotient", bus.quotient, eq);
    checkOutput("b2b second remainder", bus.remainder, er);
    @(negedge clk);

    $display("[TB] randomized operands");
    for (int i = 0; i < 150; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      if ($urandom_range(0, 9) == 0) a = 32'h80000000;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'd0 - 32'($urandom_range(1, 15));
        default: b = ($urandom_range(0, 1) == 1) ? 32'h80000000 : 32'hFFFFFFFF;
      endcase
      if (b == '0) b = 32'd1;
      refModel(sgn, a, b, eq, er);
      runVector($sformatf("rand%0d", i), sgn, a, b, eq, er, 1'b0, LAT);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
